// File: rtl/imem_loader.sv
// Loads a length-prefixed byte-stream program image into instruction memory and holds the core in reset until done.
// Build option: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the image.
module imem_loader #(
    parameter int MEM_BYTES      = 64,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              core_resetn_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [15:0]      MAX_LEN  = 16'(MEM_BYTES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              done_q, error_q, core_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    logic        xfer;
    logic [15:0] len_rx;
    logic        len_bad;

    assign xfer    = byte_valid_i && byte_ready_o;
    assign len_rx  = {len_q[15:8], byte_data_i};
    assign len_bad = (len_rx[1:0] != 2'b00) || (len_rx > MAX_LEN);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        if (busy_o) tmo_d = xfer ? '0 : tmo_q + 1'b1;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d = S_LEN_HI;
                    cnt_d   = '0;
                    tmo_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d   = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d   = {byte_data_i, 8'h00};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = len_rx;
                    if (len_bad)              state_d = S_ERR;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    else if (len_rx == 16'd0) state_d = S_CHK;
`else
                    else if (len_rx == 16'd0) state_d = S_DONE;
`endif
                    else                      state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    addr_d  = ADDR_W'(cnt_q);
                    wdata_d = byte_data_i;
                    cnt_d   = cnt_q + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ byte_data_i;
                    if (cnt_d == len_q) state_d = S_CHK;
`else
                    if (cnt_d == len_q) state_d = S_DONE;
`endif
                end
            end
            S_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (xfer) state_d = (byte_data_i == chk_q) ? S_DONE : S_ERR;
`else
                state_d = S_ERR;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // An idle host while loading abandons the image; writes already issued stay in memory.
        if (busy_o && !xfer && (tmo_q == TMO_LAST)) state_d = S_ERR;
    end

    always_comb begin
        byte_ready_o = 1'b0;
        busy_o       = 1'b0;
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA, S_CHK: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            len_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            core_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= (state_d == S_DONE);
            error_q <= (state_d == S_ERR);
            // Released one cycle after DONE entry, i.e. after the final registered write pulse.
            core_q  <= (state_q == S_DONE) && (state_d == S_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign core_resetn_o = core_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a frame-level reference model.
// Honours IMEM_LOADER_CHECKSUM_EN the same way as the design.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int MEM_BYTES      = 64;
    localparam int ADDR_W         = 32;
    localparam int TIMEOUT_CYCLES = 1024;

    logic              clk = 1'b0;
    logic              resetn;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_wdata_o;
    logic              core_resetn_o;
    logic              busy_o;
    logic              done_o;
    logic              error_o;

    imem_loader #(
        .MEM_BYTES     (MEM_BYTES),
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .start_i      (start),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .core_resetn_o(core_resetn_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]        stim[$];
    int                exp_addr[$];
    logic [7:0]        exp_data[$];
    bit                exp_ok;
    int                exp_consume;
    logic [ADDR_W-1:0] act_addr[$];
    logic [7:0]        act_data[$];

    int cyc         = 0;
    int last_we_cyc = -1;
    int rise_cyc    = -1;
    bit core_prev   = 1'b0;
    bit overlap     = 1'b0;

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (mem_we_o) begin
            act_addr.push_back(mem_addr_o);
            act_data.push_back(mem_wdata_o);
            last_we_cyc = cyc;
        end
        if (mem_we_o && core_resetn_o) overlap = 1'b1;
        if (core_resetn_o && !core_prev) rise_cyc = cyc;
        core_prev = core_resetn_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: which bytes get written and whether the frame is accepted.
    function automatic void model_load();
        int         len;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        len         = int'({stim[0], stim[1]});
        exp_consume = 2;
        exp_ok      = 1'b0;
        if ((len % 4) != 0 || len > MEM_BYTES) return;
        x = 8'h00;
        for (int k = 0; k < len; k++) begin
            exp_addr.push_back(k);
            exp_data.push_back(stim[2 + k]);
            x ^= stim[2 + k];
        end
        exp_consume = 2 + len;
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_consume++;
        exp_ok = (stim[2 + len] == x);
`else
        exp_ok = 1'b1;
`endif
    endfunction

    function automatic void build_stream(input int len, input bit bad_chk);
        logic [7:0] x;
        logic [7:0] b;
        stim.delete();
        stim.push_back(8'(len >> 8));
        stim.push_back(8'(len));
        x = 8'h00;
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            stim.push_back(b);
            x ^= b;
        end
        stim.push_back(bad_chk ? (x ^ 8'h5A) : x);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        act_addr.delete();
        act_data.delete();
        last_we_cyc = -1;
        rise_cyc    = -1;
        overlap     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, output bit ok);
        ok         = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (byte_ready_o) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    // Drives the frame in stim (with random inter-byte gaps) and compares against the model.
    task automatic run_load(input string name, input int gmin, input int gmax);
        bit ok;
        clear_mon();
        model_load();
        pulse_start();
        for (int i = 0; i < exp_consume; i++) begin
            push_byte(stim[i], ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL %s accept byte %0d: got not-ready expected ready", name, i);
            end
            if (i != exp_consume - 1) idle(gmin + int'($urandom_range(0, gmax - gmin)));
        end
        idle(4);
        vectors++;
        if (act_addr.size() != exp_addr.size()) begin
            miscompares++;
            $display("FAIL %s write count: got %0d expected %0d", name, act_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < act_addr.size(); i++) begin
            vectors++;
            if (act_addr[i] !== ADDR_W'(exp_addr[i]) || act_data[i] !== exp_data[i]) begin
                miscompares++;
                $display("FAIL %s write %0d: got %0h:%02h expected %0h:%02h",
                         name, i, act_addr[i], act_data[i], exp_addr[i], exp_data[i]);
            end
        end
        vectors++;
        if ({done_o, error_o, busy_o, core_resetn_o, overlap} !== {exp_ok, !exp_ok, 1'b0, exp_ok, 1'b0}) begin
            miscompares++;
            $display("FAIL %s status done/err/busy/core/overlap: got %b%b%b%b%b expected %b%b001%b0",
                     name, done_o, error_o, busy_o, core_resetn_o, overlap, exp_ok, !exp_ok, exp_ok);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        idle(3);
        vectors++;
        if ({byte_ready_o, mem_we_o, core_resetn_o, busy_o, done_o, error_o} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset flags: got %b expected 000000",
                     {byte_ready_o, mem_we_o, core_resetn_o, busy_o, done_o, error_o});
        end
        vectors++;
        if (mem_addr_o !== '0 || mem_wdata_o !== 8'h00) begin
            miscompares++;
            $display("FAIL reset mem bus: got %0h/%02h expected 0/00", mem_addr_o, mem_wdata_o);
        end
        resetn = 1'b1;
        idle(2);
        vectors++;
        if ({byte_ready_o, busy_o, core_resetn_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle after reset: got %b expected 000", {byte_ready_o, busy_o, core_resetn_o});
        end
    endtask

    task automatic test_directed_load();
        logic [7:0] x;
        stim = {8'h00, 8'h08, 8'h00, 8'hF0, 8'h00, 8'h93, 8'h00, 8'hC0, 8'h91, 8'h83};
        x = 8'h00;
        for (int i = 2; i < 10; i++) x ^= stim[i];
        stim.push_back(x);
        run_load("directed", 0, 0);
        vectors++;
        if (rise_cyc - last_we_cyc != 1) begin
            miscompares++;
            $display("FAIL core release delay: got %0d expected 1", rise_cyc - last_we_cyc);
        end
    endtask

    task automatic test_bad_length();
        stim = {8'h00, 8'h06};
        run_load("len6", 0, 0);
        stim = {8'h00, 8'h44};
        run_load("len68", 0, 0);
    endtask

    task automatic test_zero_length();
        stim = {8'h00, 8'h00, 8'h00};
        run_load("len0", 0, 0);
    endtask

    task automatic test_throttled_timeout();
        bit ok;
        int n;
        build_stream(4, 1'b0);
        run_load("throttled", 2, 2);
        clear_mon();
        pulse_start();
        push_byte(8'h00, ok);
        push_byte(8'h04, ok);
        push_byte(8'hAA, ok);
        vectors++;
        if (busy_o !== 1'b1 || error_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stall busy/err: got %b%b expected 10", busy_o, error_o);
        end
        n = 0;
        while (n < TIMEOUT_CYCLES + 20) begin
            @(negedge clk);
            n++;
            if (error_o) break;
        end
        vectors++;
        if (n < TIMEOUT_CYCLES - 1 || n > TIMEOUT_CYCLES + 2) begin
            miscompares++;
            $display("FAIL timeout latency: got %0d expected about %0d", n, TIMEOUT_CYCLES);
        end
        vectors++;
        if ({error_o, busy_o, done_o, core_resetn_o} !== 4'b1000) begin
            miscompares++;
            $display("FAIL timeout status err/busy/done/core: got %b expected 1000",
                     {error_o, busy_o, done_o, core_resetn_o});
        end
        vectors++;
        if (act_addr.size() != 1 || act_data[0] !== 8'hAA || act_addr[0] !== '0) begin
            miscompares++;
            $display("FAIL timeout partial write: got %0d writes expected 1 write of AA at 0", act_addr.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_ignored();
        bit ok;
        build_stream(8, 1'b0);
        clear_mon();
        model_load();
        pulse_start();
        for (int i = 0; i < exp_consume; i++) begin
            push_byte(stim[i], ok);
            if (i == 4) pulse_start();
        end
        idle(4);
        vectors++;
        if (act_addr.size() != exp_addr.size() || done_o !== 1'b1) begin
            miscompares++;
            $display("FAIL start while busy: got %0d writes done=%b expected %0d writes done=1",
                     act_addr.size(), done_o, exp_addr.size());
        end
    endtask

    task automatic test_start_in_done();
        bit ok;
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h77;
        @(posedge clk);
        #1;
        start      = 1'b0;
        byte_valid = 1'b0;
        vectors++;
        if ({busy_o, done_o, core_resetn_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL restart from done busy/done/core: got %b expected 100",
                     {busy_o, done_o, core_resetn_o});
        end
        push_byte(8'h00, ok);
        push_byte(8'h00, ok);
`ifdef IMEM_LOADER_CHECKSUM_EN
        push_byte(8'h00, ok);
`endif
        idle(2);
        vectors++;
        if (done_o !== 1'b1) begin
            miscompares++;
            $display("FAIL restart empty image done: got %b expected 1", done_o);
        end
    endtask

    task automatic test_reset_mid_data();
        bit ok;
        build_stream(16, 1'b0);
        clear_mon();
        pulse_start();
        for (int i = 0; i < 7; i++) push_byte(stim[i], ok);
        #3;
        resetn = 1'b0;
        #1;
        vectors++;
        if ({byte_ready_o, mem_we_o, core_resetn_o, busy_o, done_o, error_o} !== 6'b0
            || mem_addr_o !== '0 || mem_wdata_o !== 8'h00) begin
            miscompares++;
            $display("FAIL async reset mid-load: got flags %b addr %0h data %02h expected all zero",
                     {byte_ready_o, mem_we_o, core_resetn_o, busy_o, done_o, error_o}, mem_addr_o, mem_wdata_o);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(1);
        build_stream(8, 1'b0);
        run_load("reload", 0, 1);
    endtask

    task automatic test_random_loads();
        int len;
        bit bad;
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 4) == 0) len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 63)) | 1 : 68;
            else                           len = 4 * int'($urandom_range(0, 16));
            bad = ($urandom_range(0, 3) == 0);
            build_stream(len, bad);
            run_load($sformatf("random%0d", t), 0, 2);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        stim = {8'h00, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        run_load("chk_good", 0, 0);
        vectors++;
        if (done_o !== 1'b1) begin
            miscompares++;
            $display("FAIL chk 08 done: got %b expected 1", done_o);
        end
        stim = {8'h00, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        run_load("chk_bad", 0, 0);
        vectors++;
        if (error_o !== 1'b1) begin
            miscompares++;
            $display("FAIL chk 09 error: got %b expected 1", error_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed_load();
        test_start_in_done();
        test_bad_length();
        test_zero_length();
        test_throttled_timeout();
        test_start_ignored();
        test_reset_mid_data();
        test_random_loads();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
